// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI responder exposing a NUM_REGS x DATA_WIDTH register file plus a local access port.
//   Frame: command byte {rw, addr} then data byte(s), MSB first; rw=1 reads, rw=0 writes.
//   Ports: clk_i/arstn_i system clock and async active-low reset; sclk_i/csn_i/mosi_i/miso_o SPI pins;
//   loc_we_i/loc_addr_i/loc_wdata_i/loc_rdata_o local register port (1-cycle registered read);
//   wr_strobe_o/wr_addr_o/wr_data_o committed SPI write; rd_strobe_o read shadow loaded;
//   frame_err_o csn rose mid-frame; busy_o synchronized csn is low.
//   Define SPI_AUTO_INC_EN to keep streaming data bytes at incrementing addresses within one frame.
module spi_reg_slave #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int SPI_FREQ   = 5_000_000,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 16,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  sclk_i,
  input  logic                  csn_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  input  logic                  loc_we_i,
  input  logic [DATA_WIDTH-2:0] loc_addr_i,
  input  logic [DATA_WIDTH-1:0] loc_wdata_i,
  output logic [DATA_WIDTH-1:0] loc_rdata_o,
  output logic                  wr_strobe_o,
  output logic [DATA_WIDTH-2:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  rd_strobe_o,
  output logic                  frame_err_o,
  output logic                  busy_o
);
  localparam int AW = DATA_WIDTH - 1;
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [AW:0] NR = (AW+1)'(NUM_REGS);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic [1:0] IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2, DONE = 2'd3;
`ifdef SPI_AUTO_INC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  if (CLK_FREQ < 8 * SPI_FREQ) begin : g_freq_chk
    $error("spi_reg_slave: CLK_FREQ must be at least 8*SPI_FREQ");
  end
  logic [2:0] sclk_q, csn_q;
  logic [1:0] mosi_q;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-2:0] rx_q;
  logic [DATA_WIDTH-1:0] tx_q, rx_w, rd_val, loc_rdata_q, wr_data_q;
  logic [AW-1:0] addr_q, nxt_addr, wr_addr_q;
  logic rw_q, dd_q, miso_q, wr_stb_q, rd_stb_q, ferr_q;
  logic csn_fall, csn_rise, sample, shift, live, smp, last, cmd_end, data_end, load, commit, ferr;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  // Index [1] is the synchronized level, [2] its delayed copy used for edge detection.
  always_comb begin
    csn_fall = csn_q[2] & ~csn_q[1];
    csn_rise = ~csn_q[2] & csn_q[1];
    sample = (CPOL ^ CPHA) ? (~sclk_q[1] & sclk_q[2]) : (sclk_q[1] & ~sclk_q[2]);
    shift = (CPOL ^ CPHA) ? (sclk_q[1] & ~sclk_q[2]) : (~sclk_q[1] & sclk_q[2]);
    live = ~csn_q[1];
    smp = sample & live & (state_q == CMD || state_q == DATA);
    last = cnt_q == LAST;
    cmd_end = smp & last & (state_q == CMD);
    data_end = smp & last & (state_q == DATA);
    rx_w = {rx_q, mosi_q[1]};
    // Shadow address: decoded command on the command byte, next address on an auto-increment boundary.
    nxt_addr = cmd_end ? rx_w[AW-1:0] : addr_q + 1'b1;
    load = cmd_end ? rx_w[DATA_WIDTH-1] : (AUTO && data_end && rw_q);
    commit = data_end & ~rw_q & ({1'b0, addr_q} < NR);
    rd_val = ({1'b0, nxt_addr} < NR) ? regs_q[nxt_addr[IW-1:0]] : '0;
    // dd_q marks a completed data byte, so a rise on a later byte boundary is clean.
    ferr = csn_rise & ((state_q == CMD && cnt_q != '0) || (state_q == DATA && (cnt_q != '0 || !dd_q)));
    state_d = csn_rise ? IDLE : csn_fall ? CMD : state_q;
    cnt_d = (csn_rise | csn_fall) ? '0 : cnt_q;
    if (smp) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
      if (last) state_d = (state_q == CMD || AUTO) ? DATA : DONE;
    end
  end
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sclk_q <= {3{CPOL}};
      csn_q <= '1;
      mosi_q <= '0;
      state_q <= IDLE;
      cnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      addr_q <= '0;
      rw_q <= 1'b0;
      dd_q <= 1'b0;
      miso_q <= 1'b0;
      loc_rdata_q <= '0;
      wr_stb_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_stb_q <= 1'b0;
      ferr_q <= 1'b0;
      regs_q <= '{default: '0};
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      csn_q <= {csn_q[1:0], csn_i};
      mosi_q <= {mosi_q[0], mosi_i};
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (csn_fall) begin
        rx_q <= '0;
        dd_q <= 1'b0;
      end else if (smp) rx_q <= rx_w[DATA_WIDTH-2:0];
      if (cmd_end) rw_q <= rx_w[DATA_WIDTH-1];
      if (cmd_end || (AUTO && data_end)) addr_q <= nxt_addr;
      if (data_end) dd_q <= 1'b1;
      if (csn_fall) tx_q <= '0;
      else if (load) tx_q <= rd_val;
      else if (shift & live & (state_q == DATA)) tx_q <= tx_q << 1;
      if (csn_fall || csn_rise) miso_q <= 1'b0;
      else if (shift & live) miso_q <= (state_q == DATA) & tx_q[DATA_WIDTH-1];
      loc_rdata_q <= ({1'b0, loc_addr_i} < NR) ? regs_q[loc_addr_i[IW-1:0]] : '0;
      // The SPI commit is assigned last so it wins a same-address collision with the local port.
      if (loc_we_i && ({1'b0, loc_addr_i} < NR)) regs_q[loc_addr_i[IW-1:0]] <= loc_wdata_i;
      if (commit) begin
        regs_q[addr_q[IW-1:0]] <= rx_w;
        wr_addr_q <= addr_q;
        wr_data_q <= rx_w;
      end
      wr_stb_q <= commit;
      rd_stb_q <= load;
      ferr_q <= ferr;
    end
  end
  assign miso_o = miso_q & live;
  assign busy_o = live;
  assign loc_rdata_o = loc_rdata_q;
  assign wr_strobe_o = wr_stb_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign rd_strobe_o = rd_stb_q;
  assign frame_err_o = ferr_q;
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: scoreboard bench for spi_reg_slave across all four SPI modes.
module tb_spi_reg_slave;
  localparam int H = 8;
`ifdef SPI_AUTO_INC_EN
  localparam int RDN = 2;
`else
  localparam int RDN = 1;
`endif
  typedef struct {int m; logic [6:0] a; logic [7:0] d;} wr_t;
  logic clk = 1'b0, arstn = 1'b0, csn = 1'b1, mosi = 1'b0, loc_we = 1'b0;
  logic [3:0] sclk = 4'b1100;
  logic [6:0] loc_addr = '0;
  logic [7:0] loc_wdata = '0;
  wire [3:0] miso, wr_strobe, rd_strobe, frame_err, busy;
  wire [7:0] loc_rdata [4];
  wire [6:0] wr_addr [4];
  wire [7:0] wr_data [4];
  logic [7:0] mdl [4][16];
  wr_t exp_wr[$];
  int exp_rd[$];
  int exp_fe[$];
  int n_chk = 0, n_fail = 0;
  always #10 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_reg_slave #(.CPOL((g / 2) % 2 == 1), .CPHA(g % 2 == 1)) dut (
      .clk_i(clk), .arstn_i(arstn), .sclk_i(sclk[g]), .csn_i(csn), .mosi_i(mosi),
      .miso_o(miso[g]), .loc_we_i(loc_we), .loc_addr_i(loc_addr), .loc_wdata_i(loc_wdata),
      .loc_rdata_o(loc_rdata[g]), .wr_strobe_o(wr_strobe[g]), .wr_addr_o(wr_addr[g]),
      .wr_data_o(wr_data[g]), .rd_strobe_o(rd_strobe[g]), .frame_err_o(frame_err[g]), .busy_o(busy[g]));
  end
  always @(negedge clk) begin : mon
    wr_t e;
    int em;
    for (int m = 0; m < 4; m++) begin
      if (wr_strobe[m]) begin
        n_chk++;
        if (exp_wr.size() == 0) begin
          n_fail++;
          $display("FAIL wr_strobe: unexpected pulse mode %0d addr %0d data %h", m, wr_addr[m], wr_data[m]);
        end else begin
          e = exp_wr.pop_front();
          if (e.m != m || e.a !== wr_addr[m] || e.d !== wr_data[m]) begin
            n_fail++;
            $display("FAIL wr_strobe: got mode %0d addr %0d data %h, want mode %0d addr %0d data %h",
                     m, wr_addr[m], wr_data[m], e.m, e.a, e.d);
          end
        end
      end
      if (rd_strobe[m]) begin
        n_chk++;
        em = exp_rd.size() ? exp_rd.pop_front() : -1;
        if (em != m) begin
          n_fail++;
          $display("FAIL rd_strobe: pulse on mode %0d, want mode %0d (-1 = none)", m, em);
        end
      end
      if (frame_err[m]) begin
        n_chk++;
        em = exp_fe.size() ? exp_fe.pop_front() : -1;
        if (em != m) begin
          n_fail++;
          $display("FAIL frame_err: pulse on mode %0d, want mode %0d (-1 = none)", m, em);
        end
      end
    end
  end
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic read_loc(input int m, input logic [6:0] a, output logic [7:0] v);
    loc_addr = a;
    wait_clk(1);
    v = loc_rdata[m];
  endtask
  // Master bit-bang; col fires a local write on the cycle the last sample edge is acted upon.
  task automatic spi_xfer(input int m, input logic [23:0] tx, input int nbits, input bit col,
                          input logic [6:0] ca, input logic [7:0] cd, output logic [23:0] rx);
    logic cpol, cpha;
    cpol = m[1];
    cpha = m[0];
    rx = '0;
    csn = 1'b0;
    mosi = 1'b0;
    wait_clk(H);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = tx[23-i];
        wait_clk(H);
        rx[23-i] = miso[m];
        sclk[m] = ~cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi = tx[23-i];
        wait_clk(H);
        rx[23-i] = miso[m];
        sclk[m] = cpol;
      end
      if (col && i == nbits - 1) begin
        wait_clk(2);
        loc_we = 1'b1;
        loc_addr = ca;
        loc_wdata = cd;
        wait_clk(1);
        loc_we = 1'b0;
        wait_clk(H - 3);
      end else wait_clk(H);
      if (!cpha) sclk[m] = cpol;
    end
    wait_clk(H);
    csn = 1'b1;
    wait_clk(H);
  endtask
  task automatic spi_write(input int m, input logic [6:0] a, input logic [7:0] d);
    logic [23:0] r;
    wr_t e;
    if (a < 16) begin
      e.m = m;
      e.a = a;
      e.d = d;
      exp_wr.push_back(e);
      mdl[m][a[3:0]] = d;
    end
    spi_xfer(m, {1'b0, a, d, 8'h00}, 16, 1'b0, '0, '0, r);
  endtask
  task automatic check_drained(input string tag);
    n_chk++;
    if (exp_wr.size() || exp_rd.size() || exp_fe.size()) begin
      n_fail++;
      $display("FAIL %s: pending expected events wr=%0d rd=%0d fe=%0d, want 0", tag,
               exp_wr.size(), exp_rd.size(), exp_fe.size());
    end
  endtask
  task automatic test_reset();
    logic [7:0] v;
    arstn = 1'b0;
    wait_clk(3);
    for (int m = 0; m < 4; m++) begin
      n_chk++;
      if ({miso[m], wr_strobe[m], rd_strobe[m], frame_err[m], busy[m], wr_addr[m], wr_data[m], loc_rdata[m]} !== 28'h0) begin
        n_fail++;
        $display("FAIL reset_outputs mode %0d: got %b, want all 0", m,
                 {miso[m], wr_strobe[m], rd_strobe[m], frame_err[m], busy[m], wr_addr[m], wr_data[m], loc_rdata[m]});
      end
    end
    csn = 1'b0;
    wait_clk(3);
    n_chk++;
    if (busy !== 4'h0) begin n_fail++; $display("FAIL busy_in_reset: got %b, want 0000", busy); end
    csn = 1'b1;
    wait_clk(2);
    arstn = 1'b1;
    wait_clk(3);
    csn = 1'b0;
    wait_clk(4);
    n_chk++;
    if (busy !== 4'hf) begin n_fail++; $display("FAIL busy_low_csn: got %b, want 1111", busy); end
    csn = 1'b1;
    wait_clk(4);
    n_chk++;
    if (busy !== 4'h0) begin n_fail++; $display("FAIL busy_high_csn: got %b, want 0000", busy); end
    read_loc(0, 7'd3, v);
    n_chk++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL reset_reg3: got %h, want 00", v); end
    check_drained("reset");
  endtask
  task automatic test_write();
    logic [7:0] v;
    spi_write(0, 7'd3, 8'hA5);
    read_loc(0, 7'd3, v);
    n_chk++;
    if (v !== 8'hA5) begin n_fail++; $display("FAIL write_reg3: got %h, want a5", v); end
    check_drained("write");
  endtask
  task automatic test_read_modes();
    logic [23:0] r;
    for (int m = 0; m < 4; m++) begin
      if (m != 0) spi_write(m, 7'd3, 8'hA5);
      for (int k = 0; k < RDN; k++) exp_rd.push_back(m);
      spi_xfer(m, 24'h830000, 16, 1'b0, '0, '0, r);
      n_chk++;
      if (r[23:16] !== 8'h00) begin n_fail++; $display("FAIL read_cmd_miso mode %0d: got %h, want 00", m, r[23:16]); end
      n_chk++;
      if (r[15:8] !== mdl[m][3]) begin n_fail++; $display("FAIL read_data mode %0d: got %h, want %h", m, r[15:8], mdl[m][3]); end
    end
    check_drained("read_modes");
  endtask
  task automatic test_frame_err();
    logic [23:0] r;
    logic [7:0] v;
    exp_fe.push_back(0);
    spi_xfer(0, 24'h053C00, 12, 1'b0, '0, '0, r);
    read_loc(0, 7'd5, v);
    n_chk++;
    if (v !== mdl[0][5]) begin n_fail++; $display("FAIL frame_err_reg5: got %h, want %h", v, mdl[0][5]); end
    check_drained("frame_err");
  endtask
  task automatic test_out_of_range();
    logic [23:0] r;
    logic [7:0] v;
    spi_write(0, 7'd20, 8'hFF);
    for (int m = 0; m < 4; m++)
      for (int a = 0; a < 16; a++) begin
        read_loc(m, 7'(a), v);
        n_chk++;
        if (v !== mdl[m][a]) begin n_fail++; $display("FAIL oob_sweep mode %0d reg %0d: got %h, want %h", m, a, v, mdl[m][a]); end
      end
    read_loc(0, 7'd20, v);
    n_chk++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL oob_loc_read: got %h, want 00", v); end
    for (int k = 0; k < RDN; k++) exp_rd.push_back(0);
    spi_xfer(0, 24'h940000, 16, 1'b0, '0, '0, r);
    n_chk++;
    if (r[15:8] !== 8'h00) begin n_fail++; $display("FAIL oob_read: got %h, want 00", r[15:8]); end
    check_drained("out_of_range");
  endtask
  task automatic test_collision();
    logic [23:0] r;
    logic [7:0] v;
    wr_t e;
    e.m = 0; e.a = 7'd2; e.d = 8'h22;
    exp_wr.push_back(e);
    for (int m = 1; m < 4; m++) mdl[m][2] = 8'h11;
    mdl[0][2] = 8'h22;
    spi_xfer(0, 24'h022200, 16, 1'b1, 7'd2, 8'h11, r);
    e.m = 0; e.a = 7'd6; e.d = 8'h66;
    exp_wr.push_back(e);
    for (int m = 0; m < 4; m++) mdl[m][7] = 8'h77;
    mdl[0][6] = 8'h66;
    spi_xfer(0, 24'h066600, 16, 1'b1, 7'd7, 8'h77, r);
    for (int m = 0; m < 2; m++)
      for (int a = 2; a < 8; a++) begin
        read_loc(m, 7'(a), v);
        n_chk++;
        if (v !== mdl[m][a]) begin n_fail++; $display("FAIL collision mode %0d reg %0d: got %h, want %h", m, a, v, mdl[m][a]); end
      end
    check_drained("collision");
  endtask
  task automatic test_back_to_back();
    logic [23:0] r;
    logic [7:0] v;
    wr_t e;
    e.m = 0; e.a = 7'd15; e.d = 8'h01;
    exp_wr.push_back(e);
    mdl[0][15] = 8'h01;
    spi_xfer(0, 24'h0F0102, 24, 1'b0, '0, '0, r);
    for (int a = 14; a < 16; a++) begin
      read_loc(0, 7'(a), v);
      n_chk++;
      if (v !== mdl[0][a]) begin n_fail++; $display("FAIL multi_byte reg %0d: got %h, want %h", a, v, mdl[0][a]); end
    end
    read_loc(0, 7'd0, v);
    n_chk++;
    if (v !== mdl[0][0]) begin n_fail++; $display("FAIL multi_byte reg 0: got %h, want %h", v, mdl[0][0]); end
    check_drained("back_to_back");
  endtask
  task automatic test_reset_mid_frame();
    logic [7:0] v;
    csn = 1'b0;
    wait_clk(H);
    for (int i = 0; i < 10; i++) begin
      mosi = i[0];
      wait_clk(H);
      sclk[0] = 1'b1;
      wait_clk(H);
      sclk[0] = 1'b0;
    end
    arstn = 1'b0;
    wait_clk(2);
    n_chk++;
    if (busy !== 4'h0 || miso !== 4'h0) begin n_fail++; $display("FAIL mid_frame_reset: busy %b miso %b, want 0000 0000", busy, miso); end
    csn = 1'b1;
    wait_clk(3);
    arstn = 1'b1;
    wait_clk(5);
    for (int m = 0; m < 4; m++)
      for (int a = 0; a < 16; a++) mdl[m][a] = 8'h00;
    for (int m = 0; m < 2; m++) begin
      read_loc(m, 7'd3, v);
      n_chk++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL mid_frame_reset_reg3 mode %0d: got %h, want 00", m, v); end
    end
    spi_write(0, 7'd1, 8'h5A);
    read_loc(0, 7'd1, v);
    n_chk++;
    if (v !== 8'h5A) begin n_fail++; $display("FAIL post_reset_write: got %h, want 5a", v); end
    check_drained("reset_mid_frame");
  endtask
  initial begin
    for (int m = 0; m < 4; m++)
      for (int a = 0; a < 16; a++) mdl[m][a] = 8'h00;
    test_reset();
    test_write();
    test_read_modes();
    test_frame_err();
    test_out_of_range();
    test_collision();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
